nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Sequential wide-operand adder that splits two WORDS×4-bit operands into nibbles and runs them through a 4-bit ripple-carry nibble datapath, one nibble per cycle, LSB first.
- A registered carry is held between nibbles.
- Sits directly upstream of the combinational nibble adder: it sequences operands into that stage and collects its sum/carry outputs into a full-width result.
- Uses valid/ready handshakes on both the input and output sides.

Parameters:
- WORDS, 4, number of 4-bit nibbles per operand (operand width W = 4*WORDS); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands
- a_in  input  W  operand A
- b_in  input  W  operand B
- cin_in  input  1  carry-in to nibble 0
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer takes result
- sum_out  output  W  registered sum
- cout_out  output  1  carry out of the top nibble
- ovf_out  output  1  signed overflow flag (see Optional Feature)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst sampled high at a rising edge):
  - state=IDLE, nibble index=0, carry reg=0.
  - sum_out=0, cout_out=0, ovf_out=0, out_valid=0, busy=0.
  - in_ready is forced to 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a_in, b_in; carry reg=cin_in; idx=0; clear sum reg; go to RUN.
  - in_valid without in_ready has no effect.
- RUN:
  - in_ready=0.
  - Each edge: nibble sum = A[idx]+B[idx]+carry (4-bit ripple, full-adder equations). The result is written to sum reg bits [4*idx+3:4*idx], and carry reg takes the nibble carry-out.
  - If idx==WORDS-1: go to DONE. cout_out = final carry; ovf_out is updated per the Optional Feature. Otherwise idx increments.
- DONE:
  - out_valid=1; sum_out, cout_out and ovf_out are held stable.
  - On out_ready at an edge: out_valid drops and state returns to IDLE.
  - out_ready may be held low indefinitely; outputs must not change while it is low.
- Latency: out_valid is first high in the cycle after the WORDS-th edge following the accept edge (WORDS cycles after accept).
- Throughput: at most one operation per WORDS+2 cycles. in_ready is never high in DONE.
- Widths: all nibble arithmetic is 4-bit plus carry. The carry out of a nibble is the carry in of the next nibble only. There is no wrap beyond the top nibble; the final carry appears on cout_out only.
- Operand changes on a_in, b_in or cin_in after the accept edge are ignored.
- out_ready while not in DONE is ignored.
- WORDS=1: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: the operation is abandoned, all outputs return to reset values at that edge, and there is no spurious out_valid afterwards.
- rst takes priority over any simultaneous handshake.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN
- Defined:
  - On the final RUN edge, ovf_out = (carry into bit W-1) XOR (carry out of bit W-1), i.e. two's-complement overflow of A+B+cin.
  - ovf_out is held with sum_out in DONE and cleared on reset.
- Undefined: ovf_out is tied to 0 and no overflow logic is generated.
- Port list is identical in both builds.

Test Plan:
- WORDS=4, A=0x1234, B=0x4321, cin=0, out_ready=1 -> out_valid 4 cycles after accept; sum_out=0x5555, cout_out=0, ovf_out=0.
- A=0xFFFF, B=0x0001, cin=0 -> sum_out=0x0000, cout_out=1; ovf_out=0 (OVF_EN build).
- A=0xFFFF, B=0x0000, cin=1 -> sum_out=0x0000, cout_out=1, showing the carry rippling through all 4 nibbles.
- OVF_EN build: A=0x7FFF, B=0x0001 -> sum_out=0x8000, cout_out=0, ovf_out=1. Non-OVF build, same stimulus -> ovf_out=0.
- Backpressure: A=0x00F0, B=0x0010, out_ready low for 5 cycles in DONE -> out_valid stays 1 with sum_out=0x0100 stable, in_ready stays 0, new in_valid is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst for 1 cycle at the 2nd RUN cycle of A=0xAAAA, B=0x5555 -> outputs zero, in_ready=1 after rst is released. A following A=0x0001, B=0x0002 then yields sum_out=0x0003 with no stale nibbles.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: sums two WORDS-nibble operands one nibble per cycle, LSB first.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to generate the signed-overflow flag on ovf_out.
module nibble_serial_adder #(
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WORDS-1:0] a_in,
  input  logic [4*WORDS-1:0] b_in,
  input  logic               cin_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WORDS-1:0] sum_out,
  output logic               cout_out,
  output logic               ovf_out,
  output logic               busy
);

  localparam int unsigned W    = 4 * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q, cout_q, out_valid_q;

  logic [3:0] nib_a, nib_b, nib_sum;
  logic [4:0] c;

  // 4-bit ripple-carry stage; c[3]/c[4] bracket the top bit of the current nibble
  always_comb begin
    nib_a   = a_q[4*idx_q +: 4];
    nib_b   = b_q[4*idx_q +: 4];
    nib_sum = '0;
    c       = '0;
    c[0]    = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_sum[i] = nib_a[i] ^ nib_b[i] ^ c[i];
      c[i+1]     = (nib_a[i] & nib_b[i]) | (c[i] & (nib_a[i] ^ nib_b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[4*idx_q +: 4] <= nib_sum;
          carry_q             <= c[4];
          if (idx_q == LastIdx) begin
            cout_q      <= c[4];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && idx_q == LastIdx) begin
      ovf_q <= c[3] ^ c[4];
    end
  end

  assign ovf_out = ovf_q;
`else
  assign ovf_out = 1'b0;
`endif

  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed scoreboard bench for nibble_serial_adder (WORDS=4); expected results are
// computed from operands at accept time and popped when out_valid rises.
module tb_nibble_serial_adder;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 4 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ovf_out;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  nibble_serial_adder #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_out  (sum_out),
    .cout_out (cout_out),
    .ovf_out  (ovf_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t       e;
    logic [W:0] s;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = s[W-1:0];
    e.cout = s[W];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Accept one operand set, wait for the result, optionally stall for `hold` cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold);
    int   n;
    exp_t e;
    logic [W-1:0] held;
    out_ready = (hold == 0);
    a_in      = a;
    b_in      = b;
    cin_in    = ci;
    in_valid  = 1'b1;
    sb.push_back(model(a, b, ci));
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    cin_in   = ~ci;
    chk("busy_run", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(WORDS));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", 32'(sum_out), 32'(e.sum));
      chk("cout", 32'(cout_out), 32'(e.cout));
      chk("ovf", 32'(ovf_out), 32'(e.ovf));
    end
    held = sum_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a_in     = W'($urandom);
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum_out), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 0);
    run_op(16'h00F0, 16'h0010, 1'b0, 5);

    // Abort an operation in its second RUN cycle
    a_in     = 16'hAAAA;
    b_in     = 16'h5555;
    cin_in   = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort_sum", 32'(sum_out), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_rel", 32'(in_ready), 32'd1);
    for (int i = 0; i < WORDS + 2; i++) begin
      step();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), i);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
